// File: rtl/obi_data_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : obi_data_arbiter
//  Purpose  : Two-master / one-slave OBI arbiter sharing the data memory port
//             between the scalar core LSU (master 0) and the vector LSU
//             (master 1). Round-robin selection, request locking while a
//             request waits for grant, in-order response routing through an
//             owner-ID FIFO.
//  Revision : 1.0 - initial release
// ============================================================================
module obi_data_arbiter #(
    parameter int DEPTH = 2,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          n_reset,
    // master 0: core LSU
    input  logic          core_req_i,
    input  logic [31:0]   core_addr_i,
    input  logic          core_we_i,
    input  logic [3:0]    core_be_i,
    input  logic [31:0]   core_wdata_i,
    output logic          core_gnt_o,
    output logic          core_rvalid_o,
    output logic [31:0]   core_rdata_o,
    // master 1: vector LSU
    input  logic          vlsu_req_i,
    input  logic [31:0]   vlsu_addr_i,
    input  logic          vlsu_we_i,
    input  logic [3:0]    vlsu_be_i,
    input  logic [31:0]   vlsu_wdata_i,
    output logic          vlsu_gnt_o,
    output logic          vlsu_rvalid_o,
    output logic [31:0]   vlsu_rdata_o,
    // slave: data memory
    output logic          mem_req_o,
    output logic [31:0]   mem_addr_o,
    output logic          mem_we_o,
    output logic [3:0]    mem_be_o,
    output logic [31:0]   mem_wdata_o,
    input  logic          mem_gnt_i,
    input  logic          mem_rvalid_i,
    input  logic [31:0]   mem_rdata_i,
    // status
    output logic [CW-1:0] outstanding_o,
    output logic          proto_err_o
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // owner FIFO: 0 = core, 1 = vlsu
    logic [DEPTH-1:0] r_fifo;
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             r_last_grant;
    logic             r_lock_valid;
    logic             r_lock_owner;
    logic             r_proto_err;

    logic w_full;
    logic w_sel;
    logic w_push;
    logic w_pop;
    logic w_head;
    logic w_lock_req;

    assign w_full     = (r_count == CW'(DEPTH));
    assign w_head     = r_fifo[r_rd_ptr];
    assign w_lock_req = r_lock_owner ? vlsu_req_i : core_req_i;

    // Choose which master drives the slave this cycle; core is the idle default
    always_comb begin
        w_sel = 1'b0;
        if (!w_full) begin
            if (r_lock_valid)
                w_sel = r_lock_owner;
            else if (core_req_i && vlsu_req_i)
                w_sel = ~r_last_grant;
            else if (vlsu_req_i)
                w_sel = 1'b1;
            else
                w_sel = 1'b0;
        end
    end

    // Request mux towards the slave and grant fan-back to the selected master
    always_comb begin
        mem_req_o   = !w_full && (w_sel ? vlsu_req_i : core_req_i);
        mem_addr_o  = w_sel ? vlsu_addr_i  : core_addr_i;
        mem_we_o    = w_sel ? vlsu_we_i    : core_we_i;
        mem_be_o    = w_sel ? vlsu_be_i    : core_be_i;
        mem_wdata_o = w_sel ? vlsu_wdata_i : core_wdata_i;
        core_gnt_o  = mem_gnt_i && mem_req_o && !w_sel;
        vlsu_gnt_o  = mem_gnt_i && mem_req_o &&  w_sel;
    end

    assign w_push = mem_req_o && mem_gnt_i;
    // a response with nothing outstanding is dropped and flagged instead
    assign w_pop  = mem_rvalid_i && (r_count != '0);

    // Response routing by the registered FIFO head; read data is shared
    always_comb begin
        core_rvalid_o = w_pop && !w_head;
        vlsu_rvalid_o = w_pop &&  w_head;
        core_rdata_o  = mem_rdata_i;
        vlsu_rdata_o  = mem_rdata_i;
    end

    assign outstanding_o = r_count;
    assign proto_err_o   = r_proto_err;

    // Owner FIFO storage, pointers and occupancy
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            r_fifo   <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_fifo[r_wr_ptr] <= w_sel;
                r_wr_ptr <= (r_wr_ptr == PW'(DEPTH - 1)) ? '0 : r_wr_ptr + 1'b1;
            end
            if (w_pop)
                r_rd_ptr <= (r_rd_ptr == PW'(DEPTH - 1)) ? '0 : r_rd_ptr + 1'b1;
            if (w_push && !w_pop)
                r_count <= r_count + 1'b1;
            else if (w_pop && !w_push)
                r_count <= r_count - 1'b1;
        end
    end

    // Round-robin history, address lock and sticky protocol error
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            r_last_grant <= 1'b1;
            r_lock_valid <= 1'b0;
            r_lock_owner <= 1'b0;
            r_proto_err  <= 1'b0;
        end else begin
            if (w_push) begin
                r_last_grant <= w_sel;
                r_lock_valid <= 1'b0;
            end else if (mem_req_o) begin
                r_lock_valid <= 1'b1;
                r_lock_owner <= w_sel;
            end else if (r_lock_valid && !w_lock_req) begin
                // locked master withdrew its request before being granted
                r_lock_valid <= 1'b0;
                r_proto_err  <= 1'b1;
            end
            if (mem_rvalid_i && (r_count == '0))
                r_proto_err <= 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_obi_data_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_obi_data_arbiter
//  Purpose  : Directed self-checking bench for obi_data_arbiter (DEPTH=2)
//  Revision : 1.0 - initial release
// ============================================================================
module tb_obi_data_arbiter;

    localparam int DEPTH = 2;
    localparam int CW    = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          n_reset;
    logic          core_req_i, vlsu_req_i;
    logic [31:0]   core_addr_i, vlsu_addr_i;
    logic          core_we_i, vlsu_we_i;
    logic [3:0]    core_be_i, vlsu_be_i;
    logic [31:0]   core_wdata_i, vlsu_wdata_i;
    logic          core_gnt_o, vlsu_gnt_o;
    logic          core_rvalid_o, vlsu_rvalid_o;
    logic [31:0]   core_rdata_o, vlsu_rdata_o;
    logic          mem_req_o;
    logic [31:0]   mem_addr_o;
    logic          mem_we_o;
    logic [3:0]    mem_be_o;
    logic [31:0]   mem_wdata_o;
    logic          mem_gnt_i, mem_rvalid_i;
    logic [31:0]   mem_rdata_i;
    logic [CW-1:0] outstanding_o;
    logic          proto_err_o;

    int n_pass  = 0;
    int n_total = 0;

    obi_data_arbiter #(.DEPTH(DEPTH)) dut (
        .clk           (clk),
        .n_reset       (n_reset),
        .core_req_i    (core_req_i),
        .core_addr_i   (core_addr_i),
        .core_we_i     (core_we_i),
        .core_be_i     (core_be_i),
        .core_wdata_i  (core_wdata_i),
        .core_gnt_o    (core_gnt_o),
        .core_rvalid_o (core_rvalid_o),
        .core_rdata_o  (core_rdata_o),
        .vlsu_req_i    (vlsu_req_i),
        .vlsu_addr_i   (vlsu_addr_i),
        .vlsu_we_i     (vlsu_we_i),
        .vlsu_be_i     (vlsu_be_i),
        .vlsu_wdata_i  (vlsu_wdata_i),
        .vlsu_gnt_o    (vlsu_gnt_o),
        .vlsu_rvalid_o (vlsu_rvalid_o),
        .vlsu_rdata_o  (vlsu_rdata_o),
        .mem_req_o     (mem_req_o),
        .mem_addr_o    (mem_addr_o),
        .mem_we_o      (mem_we_o),
        .mem_be_o      (mem_be_o),
        .mem_wdata_o   (mem_wdata_o),
        .mem_gnt_i     (mem_gnt_i),
        .mem_rvalid_i  (mem_rvalid_i),
        .mem_rdata_i   (mem_rdata_i),
        .outstanding_o (outstanding_o),
        .proto_err_o   (proto_err_o)
    );

    // 100 MHz clock
    always #5 clk = ~clk;

    // Global time bound so the bench can never hang
    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    endtask

    // advance to just after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        core_req_i   = 1'b0;  vlsu_req_i   = 1'b0;
        core_addr_i  = '0;    vlsu_addr_i  = '0;
        core_we_i    = 1'b0;  vlsu_we_i    = 1'b0;
        core_be_i    = '0;    vlsu_be_i    = '0;
        core_wdata_i = '0;    vlsu_wdata_i = '0;
        mem_gnt_i    = 1'b0;  mem_rvalid_i = 1'b0;
        mem_rdata_i  = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        n_reset = 1'b0;
        @(negedge clk);
        @(negedge clk);
        n_reset = 1'b1;
        tick();
    endtask

    initial begin
        // ---------------- reset state ----------------
        idle_inputs();
        n_reset = 1'b0;
        #3;
        chk("rst_mem_req",     mem_req_o,     0);
        chk("rst_core_gnt",    core_gnt_o,    0);
        chk("rst_vlsu_gnt",    vlsu_gnt_o,    0);
        chk("rst_core_rvalid", core_rvalid_o, 0);
        chk("rst_vlsu_rvalid", vlsu_rvalid_o, 0);
        chk("rst_outstanding", outstanding_o, 0);
        chk("rst_proto_err",   proto_err_o,   0);
        do_reset();

        // ---------------- core alone ----------------
        core_req_i = 1'b1; core_addr_i = 32'h100; core_we_i = 1'b1;
        core_be_i = 4'hA; core_wdata_i = 32'h1234_5678; mem_gnt_i = 1'b1;
        #1;
        chk("t1_mem_req",   mem_req_o,   1);
        chk("t1_mem_addr",  mem_addr_o,  32'h100);
        chk("t1_mem_we",    mem_we_o,    1);
        chk("t1_mem_be",    mem_be_o,    4'hA);
        chk("t1_mem_wdata", mem_wdata_o, 32'h1234_5678);
        chk("t1_core_gnt",  core_gnt_o,  1);
        chk("t1_vlsu_gnt",  vlsu_gnt_o,  0);
        chk("t1_out0",      outstanding_o, 0);
        tick();
        core_req_i = 1'b0; core_we_i = 1'b0; mem_gnt_i = 1'b0;
        #1;
        chk("t1_out1",      outstanding_o, 1);
        chk("t1_req_idle",  mem_req_o,   0);
        tick();
        mem_rvalid_i = 1'b1; mem_rdata_i = 32'hDEAD_BEEF;
        #1;
        chk("t1_core_rvalid", core_rvalid_o, 1);
        chk("t1_vlsu_rvalid", vlsu_rvalid_o, 0);
        chk("t1_core_rdata",  core_rdata_o,  32'hDEAD_BEEF);
        tick();
        mem_rvalid_i = 1'b0;
        #1;
        chk("t1_out_back0", outstanding_o, 0);
        chk("t1_proto_ok",  proto_err_o,   0);

        // ---------------- alternation ----------------
        do_reset();
        core_req_i = 1'b1; core_addr_i = 32'h200;
        vlsu_req_i = 1'b1; vlsu_addr_i = 32'h300;
        mem_gnt_i = 1'b1;
        #1;
        chk("t2_c0_core_gnt", core_gnt_o, 1);
        chk("t2_c0_vlsu_gnt", vlsu_gnt_o, 0);
        chk("t2_c0_addr",     mem_addr_o, 32'h200);
        tick();
        mem_rvalid_i = 1'b1;
        #1;
        chk("t2_c1_vlsu_gnt",   vlsu_gnt_o,    1);
        chk("t2_c1_core_gnt",   core_gnt_o,    0);
        chk("t2_c1_addr",       mem_addr_o,    32'h300);
        chk("t2_c1_core_rv",    core_rvalid_o, 1);
        chk("t2_c1_vlsu_rv",    vlsu_rvalid_o, 0);
        tick();
        #1;
        chk("t2_c2_core_gnt",   core_gnt_o,    1);
        chk("t2_c2_vlsu_rv",    vlsu_rvalid_o, 1);
        chk("t2_c2_core_rv",    core_rvalid_o, 0);
        chk("t2_c2_out",        outstanding_o, 1);
        tick();
        #1;
        chk("t2_c3_vlsu_gnt",   vlsu_gnt_o,    1);
        chk("t2_c3_core_rv",    core_rvalid_o, 1);
        tick();
        core_req_i = 1'b0; vlsu_req_i = 1'b0; mem_gnt_i = 1'b0;
        #1;
        chk("t2_c4_vlsu_rv",    vlsu_rvalid_o, 1);
        tick();
        mem_rvalid_i = 1'b0;
        #1;
        chk("t2_out_end",       outstanding_o, 0);

        // ---------------- lock while waiting for grant ----------------
        do_reset();
        core_req_i = 1'b1; core_addr_i = 32'h400;
        vlsu_addr_i = 32'h500;
        #1;
        chk("t3_c0_addr", mem_addr_o, 32'h400);
        chk("t3_c0_gnt",  core_gnt_o, 0);
        tick();
        vlsu_req_i = 1'b1;
        #1;
        chk("t3_c1_addr", mem_addr_o, 32'h400);
        chk("t3_c1_vgnt", vlsu_gnt_o, 0);
        tick();
        #1;
        chk("t3_c2_addr", mem_addr_o, 32'h400);
        tick();
        mem_gnt_i = 1'b1;
        #1;
        chk("t3_c3_addr", mem_addr_o, 32'h400);
        chk("t3_c3_cgnt", core_gnt_o, 1);
        chk("t3_c3_vgnt", vlsu_gnt_o, 0);
        tick();
        core_req_i = 1'b0;
        #1;
        chk("t3_c4_vgnt", vlsu_gnt_o, 1);
        chk("t3_c4_addr", mem_addr_o, 32'h500);
        tick();
        vlsu_req_i = 1'b0;

        // ---------------- full FIFO blocks requests ----------------
        core_req_i = 1'b1; core_addr_i = 32'h600;
        #1;
        chk("t4_out_full",  outstanding_o, 2);
        chk("t4_req_block", mem_req_o,     0);
        chk("t4_gnt_block", core_gnt_o,    0);
        tick();
        mem_rvalid_i = 1'b1;
        #1;
        chk("t4_pop_core_rv", core_rvalid_o, 1);
        chk("t4_still_block", mem_req_o,     0);
        tick();
        mem_rvalid_i = 1'b0;
        #1;
        chk("t4_fwd_req",   mem_req_o,     1);
        chk("t4_fwd_gnt",   core_gnt_o,    1);
        chk("t4_out1",      outstanding_o, 1);
        tick();
        core_req_i = 1'b0; mem_gnt_i = 1'b0; mem_rvalid_i = 1'b1;
        #1;
        chk("t4_head_vlsu", vlsu_rvalid_o, 1);
        chk("t4_head_nc",   core_rvalid_o, 0);
        tick();
        #1;
        chk("t4_head_core", core_rvalid_o, 1);
        tick();
        mem_rvalid_i = 1'b0;
        #1;
        chk("t4_out_end",   outstanding_o, 0);

        // ---------------- spurious rvalid ----------------
        mem_rvalid_i = 1'b1;
        #1;
        chk("t5_core_rv",  core_rvalid_o, 0);
        chk("t5_vlsu_rv",  vlsu_rvalid_o, 0);
        tick();
        mem_rvalid_i = 1'b0;
        #1;
        chk("t5_err_set",  proto_err_o, 1);
        tick();
        chk("t5_err_held", proto_err_o, 1);
        n_reset = 1'b0;
        #1;
        chk("t5_err_clr",  proto_err_o, 0);
        @(negedge clk);
        n_reset = 1'b1;
        tick();

        // ---------------- reset with outstanding vlsu load ----------------
        vlsu_req_i = 1'b1; vlsu_addr_i = 32'h700; mem_gnt_i = 1'b1;
        #1;
        chk("t6_vgnt", vlsu_gnt_o, 1);
        tick();
        vlsu_req_i = 1'b0; mem_gnt_i = 1'b0;
        #1;
        chk("t6_out1", outstanding_o, 1);
        #1;
        n_reset = 1'b0;
        #1;
        chk("t6_out0",   outstanding_o, 0);
        chk("t6_cgnt",   core_gnt_o,    0);
        chk("t6_vgnt0",  vlsu_gnt_o,    0);
        chk("t6_crv",    core_rvalid_o, 0);
        chk("t6_vrv",    vlsu_rvalid_o, 0);
        @(negedge clk);
        n_reset = 1'b1;
        tick();
        mem_rvalid_i = 1'b1;
        #1;
        chk("t6_late_vrv", vlsu_rvalid_o, 0);
        tick();
        mem_rvalid_i = 1'b0;
        #1;
        chk("t6_late_err", proto_err_o, 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/obi_data_arbiter.md
# obi_data_arbiter

Two-master, one-slave OBI arbiter that shares the accelerator's single 32-bit data memory port between the scalar core LSU (master 0) and the vector LSU (master 1). Requests pass through combinationally, with fair round-robin selection and address locking while a request waits for grant. Responses are routed back to their issuer in order, using an owner-ID FIFO of outstanding transactions. The block sits between the core/vector_lsu data ports and the top-level data bus.

## Interface
Parameters:
- DEPTH, 2, max outstanding (granted, not yet rvalid) transactions; power of two, ≥1
- CW, $clog2(DEPTH+1), width of outstanding count

Ports:
- clk  in  1  clock
- n_reset  in  1  reset, asynchronous, active-low
- core_req_i / vlsu_req_i  in  1  master request
- core_addr_i / vlsu_addr_i  in  32  request address
- core_we_i / vlsu_we_i  in  1  write enable
- core_be_i / vlsu_be_i  in  4  byte enables
- core_wdata_i / vlsu_wdata_i  in  32  write data
- core_gnt_o / vlsu_gnt_o  out  1  grant to master
- core_rvalid_o / vlsu_rvalid_o  out  1  response valid to master
- core_rdata_o / vlsu_rdata_o  out  32  read data (mem_rdata_i, fanned out unconditionally)
- mem_req_o  out  1  slave request
- mem_addr_o, mem_we_o, mem_be_o, mem_wdata_o  out  32/1/4/32  muxed request fields
- mem_gnt_i  in  1  slave grant
- mem_rvalid_i  in  1  slave response valid
- mem_rdata_i  in  32  slave read data
- outstanding_o  out  CW  FIFO occupancy
- proto_err_o  out  1  sticky protocol error

## Operation
- State: owner FIFO (DEPTH x 1 bit, rd/wr pointers, count), last_grant (1 bit, reset=1 i.e. vlsu), lock_valid, lock_owner, proto_err.
- full = (count == DEPTH). If full: mem_req_o=0, both gnt=0, no selection.
- Selection (not full): if lock_valid -> lock_owner. Else only one requesting -> that one. Both -> master != last_grant. None -> mem_req_o=0.
- mem_req_o = selected master's req; mem_addr/we/be/wdata = selected master's fields (core fields when idle).
- selected_gnt_o = mem_gnt_i & mem_req_o; unselected gnt=0.
- Handshake (mem_req_o & mem_gnt_i): push owner ID, last_grant <= owner, lock_valid <= 0.
- mem_req_o & !mem_gnt_i: lock_valid <= 1, lock_owner <= selected. The other master waits regardless of priority.
- mem_rvalid_i with count>0: pop head; head==0 -> core_rvalid_o=1, else vlsu_rvalid_o=1.
- mem_rvalid_i with count==0: both rvalid=0, proto_err <= 1.
- lock_valid and locked master drops req: proto_err <= 1, lock_valid <= 0.
- Push and pop in same cycle: count unchanged, both pointers advance.
- proto_err cleared only by reset.

## Timing
- Reset: count=0, pointers=0, lock_valid=0, last_grant=1, proto_err=0. All outputs 0 with inputs idle; outstanding_o=0.
- Request path: zero-cycle combinational (req->mem_req_o, mem_gnt_i->gnt_o).
- Response path: zero-cycle combinational (mem_rvalid_i->rvalid_o), selected by registered FIFO head.
- Full check uses registered count only. A pop in the full cycle does not unblock a request until the next cycle; there is no rvalid->req combinational path.
- Lock and last_grant update on the clk edge following the relevant cycle.
- Async reset mid-transaction discards the FIFO. Responses arriving later count as proto_err.

## Test plan
- Core alone, addr 0x100, gnt same cycle; rvalid 2 cycles later -> core_gnt_o=1, mem_addr_o=0x100, core_rvalid_o=1 and vlsu_rvalid_o=0, outstanding_o 0->1->0.
- Both request continuously, mem_gnt_i=1 every cycle, rvalid 1 cycle after each gnt -> grants alternate core, vlsu, core, vlsu; rvalids route in the same order.
- Core requests with mem_gnt_i=0 for 3 cycles while vlsu raises req in cycle 1 -> mem_addr_o stays at core's address all 4 cycles; core granted in cycle 4, vlsu granted next.
- DEPTH=2: two grants with no rvalid -> third req sees mem_req_o=0 and gnt=0. rvalid arrives -> request forwarded the cycle after.
- mem_rvalid_i pulsed with outstanding_o=0 -> no rvalid outputs, proto_err_o=1 and held; n_reset low -> proto_err_o=0.
- Reset asserted with 1 outstanding vlsu load -> outstanding_o=0 immediately, all gnt/rvalid outputs 0.
